// File: rtl/serial_deframer.sv
// rtl/serial_deframer.sv - MSB-first serial receive stage with one-deep valid/ready output buffer
//
// Purpose:
//   Watches an idle-high serial line for a start bit (0), shifts in N data
//   bits MSB first, checks the stop bit (1) and hands the word to a one-deep
//   output buffer. Bad stop bits pulse frame_err; good frames that arrive
//   while the buffer is still full are dropped and latch overrun.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   bit_en     in   sample strobe; frame logic only advances when high
//   sin        in   serial line
//   ready      in   consumer takes dout when valid is high
//   dout       out  [N-1:0] received word, stable while valid
//   valid      out  dout holds an unconsumed word
//   frame_err  out  one-cycle pulse after a stop bit sampled low
//   overrun    out  sticky flag: a good frame was dropped (buffer full)
module serial_deframer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_en,
  input  logic         sin,
  input  logic         ready,
  output logic [N-1:0] dout,
  output logic         valid,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   sh_q;
  logic [N-1:0]   dout_q;
  logic           valid_q;
  logic           frame_err_q;
  logic           overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // frame_err is a single-cycle pulse; it is re-raised only by a bad stop.
      frame_err_q <= 1'b0;

      // Output handshake runs on every edge, strobe or not. A good stop on the
      // same edge overrides this below and keeps valid high with the new word.
      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!sin) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end

          DATA: begin
            sh_q  <= {sh_q[N-2:0], sin};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
              state_q <= STOP;
            end
          end

          STOP: begin
            if (sin) begin
              state_q <= IDLE;
              // Buffer counts as free if it is empty or being drained this edge.
              if (!valid_q || ready) begin
                dout_q  <= sh_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end

          WAIT_HIGH: begin
            // A line stuck low after a bad stop must not look like a new start.
            if (sin) begin
              state_q <= IDLE;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/serial_deframer.md
# serial_deframer

Serial-to-parallel receive stage that sits directly downstream of the team's N-bit shift-left register. It consumes that register's MSB-first serial output stream and detects a start bit. It then assembles N data bits, checks the stop bit, and presents the word on a one-deep valid/ready output buffer. Framing errors and overruns are flagged for the consuming logic.

## Interface
- N, default 8: data bits per frame (N >= 2).
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset); clears all state immediately, deassertion synchronous to clk in the system.
- bit_en  input  1  sample strobe; the line is sampled only on edges where bit_en=1 (tie to 1 for one bit per clock).
- sin  input  1  serial line. Idle high; frame = start(0), N data bits MSB first, stop(1).
- ready  input  1  consumer accepts dout this cycle when valid=1.
- dout  output  N  received word, held stable while valid=1.
- valid  output  1  dout holds an unconsumed word.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  sticky: a good frame was dropped because the buffer was full.

## Operation
- Internal: state (IDLE, DATA, STOP, WAIT_HIGH), bit counter of width clog2(N)+1, N-bit assembly shift register sh.
- All logic advances only on edges with bit_en=1. The exception is the output handshake, which is evaluated every edge.
- IDLE: sin=0 -> DATA, counter=0; sin=1 -> stay.
- DATA: sh <= {sh[N-2:0], sin}, counter++. When the N-th bit is taken (counter==N-1) -> STOP.
- STOP, sin=1 (good frame) -> IDLE. If the buffer is free this edge (valid=0, or valid=1 and ready=1), dout <= sh and valid <= 1. Otherwise the word is discarded and overrun <= 1.
- STOP, sin=0 -> frame_err=1 for exactly one cycle, word discarded, dout/valid untouched -> WAIT_HIGH.
- WAIT_HIGH: stay until sin=1 sampled, then -> IDLE. A held-low line must not retrigger frames.
- Handshake: valid && ready on an edge clears valid. If a good stop is taken on the same edge, valid stays 1 and dout takes the new word, with no overrun.
- overrun clears only on reset.
- Reset (any time, including mid-frame): state=IDLE, counter=0, sh=0, dout=0, valid=0, frame_err=0, overrun=0. A partial frame is lost.

## Timing
- With bit_en=1 continuously, the start bit is sampled on edge k, data on edges k+1..k+N, and stop on edge k+N+1. valid and dout are visible after edge k+N+1, i.e. N+2 edges from the start sample.
- Back-to-back frames: a start bit may be sampled on the edge immediately after the stop edge (zero idle bits).
- With a gapped bit_en, latency scales with strobes. Strobe-less cycles hold all frame state.
- dout and valid are registered outputs with no combinational path from sin or ready.
- frame_err is registered, high for exactly the cycle following the bad-stop edge.
- The consumer may hold ready high permanently. A word is then consumed one edge after valid rises.

## Test plan
- N=8, bit_en=1, ready=0, stream 0,1,0,1,0,0,1,0,1,1 (0xA5) -> valid=1, dout=0xA5 after the 10th edge; held while ready=0. Then ready=1 for one cycle -> valid=0.
- Two back-to-back frames 0x3C then 0xC3, ready=1 constant -> valid pulses once per frame with dout=0x3C then 0xC3, no idle bits between them, overrun=0.
- Frame 0x5A with stop bit 0, line held low 5 more bits, then high -> frame_err high exactly one cycle, valid stays 0, no new frame starts until sin returns to 1. A following 0x81 frame is then received correctly.
- ready=0, frames 0x11 then 0x22 -> dout stays 0x11, overrun=1 after the second stop. Repeat with ready=1 on the second stop edge -> dout=0x22, valid=1, overrun=0.
- bit_en high one cycle in three, frame 0xF0 -> dout=0xF0 after the stop strobe; sh and state unchanged on non-strobe cycles.
- reset pulled low after the 4th data bit of a frame -> all outputs 0 immediately (asynchronous). After release, the next full 0x99 frame is received correctly.
